// File: rtl/keccak_absorb_buffer.sv
// Keccak absorb-side input buffer: packs a byte stream into rate-sized
// blocks, applies SHA-3/SHAKE multi-rate padding and hands blocks out.
module keccak_absorb_buffer #(
    parameter int DW = 64,
    parameter int BW = $clog2(DW/8)+1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [2:0]    cmode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic [BW-1:0] in_bytes,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [1343:0] blk_data,
    output logic          blk_first,
    output logic          blk_last
);

    localparam int NB = DW/8;

    typedef enum logic [1:0] {FILL, HOLD, HOLD_PAD} state_t;

    state_t         state_q, state_nx;
    logic [1343:0]  blk_q, blk_nx;
    logic [7:0]     cnt_q, cnt_nx;
    logic [7:0]     rate_q, rate_nx;
    logic [7:0]     dom_q, dom_nx;
    logic           first_q, first_nx;
    logic           pend_q, pend_nx;
    logic           last_q, last_nx;

    logic           accept;
    logic           sample;
    logic [7:0]     rate_eff;
    logic [7:0]     dom_eff;
    logic [7:0]     bcnt;
    logic [7:0]     pos;
    logic [7:0]     byte_v;

    function automatic logic [7:0] rate_of(input logic [2:0] m);
        logic [7:0] r;
        case (m)
            3'd0:    r = 8'd144;
            3'd2:    r = 8'd104;
            3'd3:    r = 8'd72;
            3'd4:    r = 8'd168;
            default: r = 8'd136;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] dom_of(input logic [2:0] m);
        return (m == 3'd4 || m == 3'd5) ? 8'h1F : 8'h06;
    endfunction

    // Outputs come straight from state registers only.
    assign in_ready  = (state_q == FILL);
    assign blk_valid = (state_q != FILL);
    assign blk_data  = blk_q;
    assign blk_first = blk_valid && first_q;
    assign blk_last  = (state_q == HOLD_PAD) || (state_q == HOLD && last_q);

    // Next-state, packing and padding logic.
    always_comb begin
        state_nx = state_q;
        blk_nx   = blk_q;
        cnt_nx   = cnt_q;
        rate_nx  = rate_q;
        dom_nx   = dom_q;
        first_nx = first_q;
        pend_nx  = pend_q;
        last_nx  = last_q;
        byte_v   = 8'h00;

        accept   = (state_q == FILL) && in_valid;
        sample   = accept && (cnt_q == 8'd0) && first_q;
        rate_eff = sample ? rate_of(cmode) : rate_q;
        dom_eff  = sample ? dom_of(cmode) : dom_q;
        bcnt     = in_last ? 8'(in_bytes) : 8'(NB);
        pos      = cnt_q + bcnt;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    rate_nx = rate_eff;
                    dom_nx  = dom_eff;
                    cnt_nx  = cnt_q + 8'(NB);
                    for (int j = 0; j < NB; j++) begin
                        byte_v = (!in_last || j < int'(bcnt))
                               ? in_data[DW-1-8*j -: 8] : 8'h00;
                        blk_nx[8*(int'(cnt_q)+j) +: 8] = byte_v;
                    end
                    if (in_last) begin
                        state_nx = HOLD;
                        if (pos < rate_eff) begin
                            blk_nx[8*int'(pos) +: 8] =
                                blk_nx[8*int'(pos) +: 8] | dom_eff;
                            blk_nx[8*(int'(rate_eff)-1) +: 8] =
                                blk_nx[8*(int'(rate_eff)-1) +: 8] | 8'h80;
                            last_nx = 1'b1;
                        end else begin
                            last_nx = 1'b0;
                            pend_nx = 1'b1;
                        end
                    end else if (cnt_q + 8'(NB) == rate_eff) begin
                        state_nx = HOLD;
                        last_nx  = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    if (pend_q) begin
                        blk_nx        = '0;
                        blk_nx[7:0]   = dom_q;
                        blk_nx[8*(int'(rate_q)-1) +: 8] = 8'h80;
                        pend_nx  = 1'b0;
                        first_nx = 1'b0;
                        state_nx = HOLD_PAD;
                    end else begin
                        blk_nx   = '0;
                        cnt_nx   = 8'd0;
                        first_nx = last_q;
                        state_nx = FILL;
                    end
                end
            end
            HOLD_PAD: begin
                if (blk_ready) begin
                    blk_nx   = '0;
                    cnt_nx   = 8'd0;
                    first_nx = 1'b1;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase

        // Abort wins over any accept or transfer in the same cycle.
        if (clr) begin
            blk_nx   = '0;
            cnt_nx   = 8'd0;
            pend_nx  = 1'b0;
            last_nx  = 1'b0;
            first_nx = 1'b1;
            state_nx = FILL;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            blk_q   <= '0;
            cnt_q   <= 8'd0;
            rate_q  <= 8'd136;
            dom_q   <= 8'h06;
            first_q <= 1'b1;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            blk_q   <= blk_nx;
            cnt_q   <= cnt_nx;
            rate_q  <= rate_nx;
            dom_q   <= dom_nx;
            first_q <= first_nx;
            pend_q  <= pend_nx;
            last_q  <= last_nx;
        end
    end

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Directed bench for keccak_absorb_buffer: 64-bit and 32-bit instances,
// expected blocks built from a reference pad10*1 model.
module tb_keccak_absorb_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          sel;
    logic [2:0]    cmode;
    logic          in_valid;
    logic          in_last;
    logic          blk_ready;
    logic [63:0]   wd;
    logic [3:0]    nb;

    logic          r64, v64, f64, l64;
    logic          r32, v32, f32, l32;
    logic [1343:0] d64, d32;

    logic          in_ready, blk_valid, blk_first, blk_last;
    logic [1343:0] blk_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keccak_absorb_buffer #(.DW(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cmode(cmode),
        .in_valid(in_valid && !sel), .in_ready(r64),
        .in_data(wd), .in_last(in_last), .in_bytes(nb),
        .blk_valid(v64), .blk_ready(blk_ready && !sel),
        .blk_data(d64), .blk_first(f64), .blk_last(l64)
    );

    keccak_absorb_buffer #(.DW(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cmode(cmode),
        .in_valid(in_valid && sel), .in_ready(r32),
        .in_data(wd[63:32]), .in_last(in_last), .in_bytes(nb[2:0]),
        .blk_valid(v32), .blk_ready(blk_ready && sel),
        .blk_data(d32), .blk_first(f32), .blk_last(l32)
    );

    assign in_ready  = sel ? r32 : r64;
    assign blk_valid = sel ? v32 : v64;
    assign blk_data  = sel ? d32 : d64;
    assign blk_first = sel ? f32 : f64;
    assign blk_last  = sel ? l32 : l64;

    function automatic logic [7:0] mb(input int q);
        return 8'((q * 37 + 5) & 255);
    endfunction

    // Reference: block k of message length n padded with pad10*1.
    function automatic logic [1343:0] expblk(input int n, input int r,
                                             input logic [7:0] d,
                                             input int k);
        logic [1343:0] e;
        logic [7:0]    v;
        int            len;
        int            q;
        e   = '0;
        len = (n / r + 1) * r;
        for (int i = 0; i < r; i++) begin
            q = k * r + i;
            v = (q < n) ? mb(q) : 8'h00;
            if (q == n)       v = v | d;
            if (q == len - 1) v = v | 8'h80;
            e[8*i +: 8] = v;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [1343:0] o,
                       input logic [1343:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, o, e);
        end
    endtask

    task automatic send_msg(input int n, input logic [2:0] cm,
                            input logic fin);
        int w;
        int nw;
        int t;
        int q;
        w  = sel ? 4 : 8;
        nw = (n + w - 1) / w;
        if (nw == 0) nw = 1;
        for (int i = 0; i < nw; i++) begin
            wd = '0;
            for (int j = 0; j < w; j++) begin
                q = i * w + j;
                wd[63-8*j -: 8] = (q < n) ? mb(q) : 8'hEE;
            end
            in_last = fin && (i == nw - 1);
            nb      = in_last ? 4'(n - i * w) : 4'd0;
            cmode   = (i == 0) ? cm : 3'd2;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 2000) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) chk1("send_timeout", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic recv(input logic [1343:0] e, input logic ef,
                        input logic el, input string tag);
        int t;
        t = 0;
        while (!blk_valid && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk1({tag, "_valid"}, blk_valid, 1'b1);
        chk({tag, "_data"}, blk_data, e);
        chk1({tag, "_first"}, blk_first, ef);
        chk1({tag, "_last"}, blk_last, el);
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1343:0] e0;
        rst_n = 1'b0; clr = 1'b0; sel = 1'b0; cmode = 3'd1;
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        wd = '0; nb = '0;
        #12;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk_data", blk_data, '0);
        chk1("rst_blk_first", blk_first, 1'b0);
        chk1("rst_blk_last", blk_last, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        send_msg(0, 3'd1, 1'b1);
        recv(expblk(0, 136, 8'h06, 0), 1'b1, 1'b1, "sha256_empty");

        send_msg(71, 3'd3, 1'b1);
        recv(expblk(71, 72, 8'h06, 0), 1'b1, 1'b1, "sha512_71");

        send_msg(168, 3'd4, 1'b1);
        recv(expblk(168, 168, 8'h1F, 0), 1'b1, 1'b0, "shake_b0");
        recv(expblk(168, 168, 8'h1F, 1), 1'b0, 1'b1, "shake_b1");

        send_msg(104, 3'd2, 1'b0);
        e0 = expblk(104, 104, 8'h06, 0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_data", blk_data, e0);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_valid", blk_valid, 1'b1);
            @(posedge clk); #1;
        end
        recv(e0, 1'b1, 1'b0, "bp_b0");
        chk1("bp_ready_after", in_ready, 1'b1);
        chk1("bp_valid_after", blk_valid, 1'b0);
        send_msg(0, 3'd2, 1'b1);
        recv(expblk(104, 104, 8'h06, 1), 1'b0, 1'b1, "bp_b1");

        send_msg(24, 3'd3, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk1("clr_in_ready", in_ready, 1'b1);
        chk1("clr_valid", blk_valid, 1'b0);
        send_msg(0, 3'd0, 1'b1);
        recv(expblk(0, 144, 8'h06, 0), 1'b1, 1'b1, "clr_sha224");

        send_msg(0, 3'd7, 1'b1);
        recv(expblk(0, 136, 8'h06, 0), 1'b1, 1'b1, "mode7");

        sel = 1'b1;
        @(posedge clk); #1;
        fork
            send_msg(137, 3'd1, 1'b1);
            begin
                recv(expblk(137, 136, 8'h06, 0), 1'b1, 1'b0, "w32_b0");
                recv(expblk(137, 136, 8'h06, 1), 1'b0, 1'b1, "w32_b1");
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
